load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Pipeline stage that sits between execute and the data RAM. Turns execute-stage
//  load/store ops into RAM requests: word address, read strobe, byte-lane write
//  mask and lane-replicated store data. One cycle later it aligns and extends the
//  read word for writeback. Single-entry response slot; in order; valid/ready on
//  both sides.
// PARAMETERS
//  none
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  resetn       in   1   synchronous active-low reset
//  exValid      in   1   execute offers an op
//  exReady      out  1   op accepted this cycle when exValid&exReady ("issue")
//  exIsLoad     in   1   op is a load
//  exIsStore    in   1   op is a store
//  exFunct3     in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  exAddr       in   32  effective byte address (rs1+imm)
//  exStoreData  in   32  rs2 value
//  exRd         in   5   destination register
//  memAddr      out  32  byte address to RAM; RAM uses [31:2]
//  memRstrb     out  1   read strobe; RAM data valid the following cycle
//  memWData     out  32  lane-replicated store data
//  memWMask     out  4   byte write enables
//  memRData     in   32  RAM read word, registered in RAM, held until next strobe
//  wbValid      out  1   response slot occupied
//  wbReady      in   1   writeback consumes slot when wbValid&wbReady
//  wbWrite      out  1   write wbData to wbRd
//  wbRd         out  5   destination register of response
//  wbData       out  32  aligned/extended load data (0 when wbWrite=0)
//  wbMisalign   out  1   response is a suppressed misaligned access
// BEHAVIOUR
//  - exReady = resetn & (!wbValid | wbReady). One op in flight; a new read is never
//    issued while a load response is unconsumed, so memRData stays stable.
//  - RAM outputs combinational from ex* inputs, gated by issue: memAddr=exAddr;
//    memRstrb=issue&exIsLoad&!mis; memWMask=0 unless issue&exIsStore&!exIsLoad&!mis.
//  - Store lanes, a=exAddr[1:0]: SB mask 4'b0001<<a, data {4{d[7:0]}};
//    SH mask 4'b0011<<{a[1],1'b0}, data {2{d[15:0]}}; SW (funct3[1:0]=2 or 3) mask
//    4'b1111, data d. funct3[2] ignored for stores.
//  - Load funct3 3/6/7 treated as LW. exIsLoad&exIsStore: load wins.
//    Neither set: consumed, no RAM access, response with wbWrite=0.
//  - On issue the slot registers: valid=1, isLoad, funct3, addr[1:0], rd, mis.
//    On consume without issue: valid=0. Issue and consume same cycle: slot reloads.
//  - Load result: w=memRData>>(8*addr[1:0]); LB {{24{w[7]}},w[7:0]}; LBU zero-ext
//    w[7:0]; LH {{16{w[15]}},w[15:0]}; LHU zero-ext w[15:0]; LW memRData.
//  - Latency: issue cycle N -> wbValid and wbData valid cycle N+1, stall-held.
//  - wbWrite = valid & isLoad & !mis & (rd!=0). Stores respond with wbWrite=0
//    (keeps order).
//  - Reset: slot valid/fields cleared -> wbValid=0, wbWrite=0, wbRd=0, wbData=0,
//    wbMisalign=0, exReady=0, memRstrb=0, memWMask=0. Pending response is
//    discarded; no RAM access during reset.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: mis = (half & exAddr[0]) | (word & |exAddr[1:0]);
//    a mis op does no RAM access, responds wbWrite=0, wbMisalign=1.
//  Undefined: mis=0, wbMisalign tied 0. Halfword uses lane pair per exAddr[1]; word
//    ignores exAddr[1:0]; access proceeds.
// TESTING
//  - SW addr 0x100 data 0xDEADBEEF -> mask 1111, WData 0xDEADBEEF; LW 0x100 ->
//    wbData 0xDEADBEEF next cycle.
//  - SB addr 0x103 data 0x000000A5 -> mask 1000, WData 0xA5A5A5A5; LB 0x103 ->
//    0xFFFFFFA5; LBU -> 0x000000A5.
//  - LH 0x102 on word 0x80017FFF -> 0xFFFF8001; LHU -> 0x00008001.
//  - wbReady=0 three cycles with load pending -> exReady=0, memRstrb=0, wbData
//    held; release -> next op issues same cycle.
//  - LW 0x101 with LSU_MISALIGN_TRAP_EN -> memRstrb=0, wbMisalign=1, wbWrite=0;
//    without -> reads word 0x100.
//  - resetn low with load pending -> next cycle wbValid=0, no writeback; LW rd=x0
//    -> wbWrite=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: execute-side request, data RAM port and
// writeback response. The LSU takes the slave view; the surrounding pipeline
// and RAM take the master view.
interface load_store_unit_if;
  logic        exValid;
  logic        exReady;
  logic        exIsLoad;
  logic        exIsStore;
  logic [2:0]  exFunct3;
  logic [31:0] exAddr;
  logic [31:0] exStoreData;
  logic [4:0]  exRd;

  logic [31:0] memAddr;
  logic        memRstrb;
  logic [31:0] memWData;
  logic [3:0]  memWMask;
  logic [31:0] memRData;

  logic        wbValid;
  logic        wbReady;
  logic        wbWrite;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        wbMisalign;

  modport slave (
    input  exValid, exIsLoad, exIsStore, exFunct3, exAddr, exStoreData, exRd,
    input  memRData, wbReady,
    output exReady, memAddr, memRstrb, memWData, memWMask,
    output wbValid, wbWrite, wbRd, wbData, wbMisalign
  );

  modport master (
    output exValid, exIsLoad, exIsStore, exFunct3, exAddr, exStoreData, exRd,
    output memRData, wbReady,
    input  exReady, memAddr, memRstrb, memWData, memWMask,
    input  wbValid, wbWrite, wbRd, wbData, wbMisalign
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage loads/stores into data RAM requests
// (word address, read strobe, byte write mask, lane-replicated store data) and,
// one cycle later, aligns and sign/zero-extends the read word for writeback.
// A single response slot keeps exactly one op in flight, in order.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to suppress misaligned
// halfword/word accesses (no RAM access, response flagged wbMisalign).
module load_store_unit (
  input  logic clk,
  input  logic resetn,
  load_store_unit_if.slave bus
);

  logic        issue;
  logic        op_load;
  logic        op_store;
  logic        op_half;
  logic        op_word;
  logic        mis;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;

  logic        slot_valid;
  logic        slot_load;
  logic [2:0]  slot_funct3;
  logic [1:0]  slot_addr;
  logic [4:0]  slot_rd;
  logic        slot_mis;

  logic [1:0]  rd_lane;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        wb_write;

  // A new op is accepted only when the slot is free or being drained now,
  // so the RAM read word stays stable while a load response waits.
  assign bus.exReady = resetn & (~slot_valid | bus.wbReady);
  assign issue       = bus.exValid & bus.exReady;

  // Load takes priority when execute flags both kinds of access.
  assign op_load  = bus.exIsLoad;
  assign op_store = bus.exIsStore & ~bus.exIsLoad;
  assign op_half  = (bus.exFunct3[1:0] == 2'b01);
  assign op_word  = bus.exFunct3[1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (op_load | op_store) &
               ((op_half & bus.exAddr[0]) | (op_word & (|bus.exAddr[1:0])));
`else
  assign mis = 1'b0;
`endif

  // Store lane selection and data replication by access size.
  always_comb begin
    lane_mask = 4'b0001 << bus.exAddr[1:0];
    lane_data = {4{bus.exStoreData[7:0]}};
    if (op_word) begin
      lane_mask = 4'b1111;
      lane_data = bus.exStoreData;
    end else if (op_half) begin
      lane_mask = 4'b0011 << {bus.exAddr[1], 1'b0};
      lane_data = {2{bus.exStoreData[15:0]}};
    end
  end

  assign bus.memAddr  = bus.exAddr;
  assign bus.memWData = lane_data;
  assign bus.memRstrb = issue & op_load & ~mis;
  assign bus.memWMask = (issue & op_store & ~mis) ? lane_mask : 4'b0000;

  // Response slot: loads on issue, empties when consumed without a new issue.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_valid  <= 1'b0;
      slot_load   <= 1'b0;
      slot_funct3 <= 3'b000;
      slot_addr   <= 2'b00;
      slot_rd     <= 5'd0;
      slot_mis    <= 1'b0;
    end else if (issue) begin
      slot_valid  <= 1'b1;
      slot_load   <= op_load;
      slot_funct3 <= bus.exFunct3;
      slot_addr   <= bus.exAddr[1:0];
      slot_rd     <= bus.exRd;
      slot_mis    <= mis;
    end else if (bus.wbReady) begin
      slot_valid  <= 1'b0;
    end
  end

  // Align the registered RAM word to the accessed lane and extend it.
  always_comb begin
    rd_lane   = (slot_funct3[1:0] == 2'b01) ? {slot_addr[1], 1'b0} : slot_addr;
    shifted   = bus.memRData >> {rd_lane, 3'b000};
    load_data = bus.memRData;
    case (slot_funct3[1:0])
      2'b00: load_data = slot_funct3[2] ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_data = slot_funct3[2] ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = bus.memRData;
    endcase
  end

  assign wb_write       = slot_valid & slot_load & ~slot_mis & (slot_rd != 5'd0);
  assign bus.wbValid    = slot_valid;
  assign bus.wbWrite    = wb_write;
  assign bus.wbRd       = slot_rd;
  assign bus.wbData     = wb_write ? load_data : 32'd0;
  assign bus.wbMisalign = slot_valid & slot_mis;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a small behavioural RAM serves the
// memory port, directed ops push hand-computed responses, and a monitor pops
// and compares each response the unit hands to writeback.
module tb_load_store_unit;

  logic clk;
  logic resetn;
  int   tests_run;
  int   tests_failed;

  load_store_unit_if ifc ();

  load_store_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        write;
    logic [31:0] data;
    logic        mis;
  } resp_t;

  resp_t       sb[$];
  resp_t       exp_resp;
  logic [31:0] ram [0:255];

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural data RAM: registered read on strobe, byte-lane writes.
  always @(posedge clk) begin
    if (ifc.memRstrb) ifc.memRData <= ram[ifc.memAddr[9:2]];
    for (int i = 0; i < 4; i++)
      if (ifc.memWMask[i]) ram[ifc.memAddr[9:2]][8*i +: 8] <= ifc.memWData[8*i +: 8];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Response monitor: compare every consumed response against the scoreboard.
  always @(negedge clk) begin
    if (resetn && ifc.wbValid && ifc.wbReady) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_response: got rd %0d data %h expected none",
                 ifc.wbRd, ifc.wbData);
      end else begin
        exp_resp = sb.pop_front();
        checkOutput("wb_rd",       ifc.wbRd,       exp_resp.rd);
        checkOutput("wb_write",    ifc.wbWrite,    exp_resp.write);
        checkOutput("wb_data",     ifc.wbData,     exp_resp.data);
        checkOutput("wb_misalign", ifc.wbMisalign, exp_resp.mis);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic ld, input logic st,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data, input logic [4:0] rd,
                               input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                               input logic exp_rstrb, input logic exp_write,
                               input logic [31:0] exp_data, input logic exp_mis,
                               output int waited);
    resp_t r;
    ifc.exValid     = 1'b1;
    ifc.exIsLoad    = ld;
    ifc.exIsStore   = st;
    ifc.exFunct3    = f3;
    ifc.exAddr      = addr;
    ifc.exStoreData = data;
    ifc.exRd        = rd;
    waited = 0;
    @(negedge clk);
    while (!ifc.exReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ifc.exReady) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_issue_timeout: got exReady 0 expected 1", name);
      ifc.exValid = 1'b0;
      return;
    end
    checkOutput({name, "_mask"},  ifc.memWMask, exp_mask);
    checkOutput({name, "_rstrb"}, ifc.memRstrb, exp_rstrb);
    if (exp_mask != 4'b0000) checkOutput({name, "_wdata"}, ifc.memWData, exp_wdata);
    if (exp_mask != 4'b0000 || exp_rstrb) checkOutput({name, "_addr"}, ifc.memAddr, addr);
    r.rd = rd; r.write = exp_write; r.data = exp_data; r.mis = exp_mis;
    sb.push_back(r);
    @(posedge clk);
    #1;
    ifc.exValid = 1'b0;
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int w;
    tests_run = 0;
    tests_failed = 0;
    resetn = 1'b0;
    ifc.exValid = 1'b0; ifc.exIsLoad = 1'b0; ifc.exIsStore = 1'b0;
    ifc.exFunct3 = 3'd0; ifc.exAddr = 32'd0; ifc.exStoreData = 32'd0; ifc.exRd = 5'd0;
    ifc.wbReady = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wbvalid",  ifc.wbValid,    1'b0);
    checkOutput("rst_wbwrite",  ifc.wbWrite,    1'b0);
    checkOutput("rst_wbrd",     ifc.wbRd,       5'd0);
    checkOutput("rst_wbdata",   ifc.wbData,     32'd0);
    checkOutput("rst_misalign", ifc.wbMisalign, 1'b0);
    checkOutput("rst_exready",  ifc.exReady,    1'b0);
    checkOutput("rst_rstrb",    ifc.memRstrb,   1'b0);
    checkOutput("rst_mask",     ifc.memWMask,   4'b0000);
    @(posedge clk); #1;
    resetn = 1'b1;

    applyStimulus("sw100",  0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd1, 4'b1111, 32'hDEADBEEF, 0, 0, 32'h0, 0, w);
    applyStimulus("lw100",  1, 0, 3'd2, 32'h100, 32'h0, 5'd5, 4'b0000, 32'h0, 1, 1, 32'hDEADBEEF, 0, w);
    applyStimulus("sb103",  0, 1, 3'd0, 32'h103, 32'h000000A5, 5'd0, 4'b1000, 32'hA5A5A5A5, 0, 0, 32'h0, 0, w);
    applyStimulus("lb103",  1, 0, 3'd0, 32'h103, 32'h0, 5'd6, 4'b0000, 32'h0, 1, 1, 32'hFFFFFFA5, 0, w);
    applyStimulus("lbu103", 1, 0, 3'd4, 32'h103, 32'h0, 5'd7, 4'b0000, 32'h0, 1, 1, 32'h000000A5, 0, w);
    applyStimulus("sw_half_word", 0, 1, 3'd2, 32'h100, 32'h80017FFF, 5'd0, 4'b1111, 32'h80017FFF, 0, 0, 32'h0, 0, w);
    applyStimulus("lh102",  1, 0, 3'd1, 32'h102, 32'h0, 5'd8, 4'b0000, 32'h0, 1, 1, 32'hFFFF8001, 0, w);
    applyStimulus("lhu102", 1, 0, 3'd5, 32'h102, 32'h0, 5'd8, 4'b0000, 32'h0, 1, 1, 32'h00008001, 0, w);
    applyStimulus("lh100",  1, 0, 3'd1, 32'h100, 32'h0, 5'd9, 4'b0000, 32'h0, 1, 1, 32'h00007FFF, 0, w);
    applyStimulus("lb100",  1, 0, 3'd0, 32'h100, 32'h0, 5'd9, 4'b0000, 32'h0, 1, 1, 32'hFFFFFFFF, 0, w);
    applyStimulus("sh102",  0, 1, 3'd1, 32'h102, 32'h1234ABCD, 5'd0, 4'b1100, 32'hABCDABCD, 0, 0, 32'h0, 0, w);
    applyStimulus("lw_f3_3", 1, 0, 3'd3, 32'h100, 32'h0, 5'd4, 4'b0000, 32'h0, 1, 1, 32'hABCD7FFF, 0, w);

    // Hold writeback off for three cycles with a load response pending.
    applyStimulus("lw_stall", 1, 0, 3'd2, 32'h100, 32'h0, 5'd9, 4'b0000, 32'h0, 1, 1, 32'hABCD7FFF, 0, w);
    ifc.wbReady = 1'b0;
    ifc.exValid = 1'b1; ifc.exIsLoad = 1'b1; ifc.exIsStore = 1'b0;
    ifc.exFunct3 = 3'd4; ifc.exAddr = 32'h100; ifc.exRd = 5'd10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("stall_exready", ifc.exReady,  1'b0);
      checkOutput("stall_rstrb",   ifc.memRstrb, 1'b0);
      checkOutput("stall_wbvalid", ifc.wbValid,  1'b1);
      checkOutput("stall_wbdata",  ifc.wbData,   32'hABCD7FFF);
      @(posedge clk); #1;
    end
    ifc.wbReady = 1'b1;
    applyStimulus("lbu_release", 1, 0, 3'd4, 32'h100, 32'h0, 5'd10, 4'b0000, 32'h0, 1, 1, 32'h000000FF, 0, w);
    checkOutput("release_same_cycle", w, 32'd0);

    // Reset with a load response pending discards it.
    applyStimulus("lw_reset", 1, 0, 3'd2, 32'h100, 32'h0, 5'd11, 4'b0000, 32'h0, 1, 1, 32'hABCD7FFF, 0, w);
    ifc.wbReady = 1'b0;
    resetn = 1'b0;
    ifc.exValid = 1'b1; ifc.exIsLoad = 1'b0; ifc.exIsStore = 1'b1;
    ifc.exFunct3 = 3'd2; ifc.exAddr = 32'h100; ifc.exStoreData = 32'h0BADF00D; ifc.exRd = 5'd0;
    @(negedge clk);
    checkOutput("rstpend_exready", ifc.exReady,  1'b0);
    checkOutput("rstpend_mask",    ifc.memWMask, 4'b0000);
    checkOutput("rstpend_wbvalid", ifc.wbValid,  1'b1);
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    checkOutput("rstdone_wbvalid", ifc.wbValid, 1'b0);
    checkOutput("rstdone_wbwrite", ifc.wbWrite, 1'b0);
    checkOutput("rstdone_wbdata",  ifc.wbData,  32'd0);
    checkOutput("rstdone_wbrd",    ifc.wbRd,    5'd0);
    checkOutput("rstdone_mask",    ifc.memWMask, 4'b0000);
    @(posedge clk); #1;
    ifc.exValid = 1'b0;
    resetn = 1'b1;
    ifc.wbReady = 1'b1;

    applyStimulus("lw_rd0",   1, 0, 3'd2, 32'h100, 32'h0, 5'd0, 4'b0000, 32'h0, 1, 0, 32'h0, 0, w);
    applyStimulus("ld_and_st", 1, 1, 3'd2, 32'h100, 32'hFFFFFFFF, 5'd13, 4'b0000, 32'h0, 1, 1, 32'hABCD7FFF, 0, w);
    applyStimulus("neither",  0, 0, 3'd2, 32'h100, 32'h0, 5'd14, 4'b0000, 32'h0, 0, 0, 32'h0, 0, w);
    applyStimulus("lw_f3_7",  1, 0, 3'd7, 32'h100, 32'h0, 5'd15, 4'b0000, 32'h0, 1, 1, 32'hABCD7FFF, 0, w);
    applyStimulus("sw_f3_6",  0, 1, 3'd6, 32'h104, 32'h11223344, 5'd0, 4'b1111, 32'h11223344, 0, 0, 32'h0, 0, w);
    applyStimulus("lb105",    1, 0, 3'd0, 32'h105, 32'h0, 5'd16, 4'b0000, 32'h0, 1, 1, 32'h00000033, 0, w);
    applyStimulus("lh106",    1, 0, 3'd1, 32'h106, 32'h0, 5'd17, 4'b0000, 32'h0, 1, 1, 32'h00001122, 0, w);
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus("lw101_mis", 1, 0, 3'd2, 32'h101, 32'h0, 5'd12, 4'b0000, 32'h0, 0, 0, 32'h0, 1, w);
`else
    applyStimulus("lw101",     1, 0, 3'd2, 32'h101, 32'h0, 5'd12, 4'b0000, 32'h0, 1, 1, 32'hABCD7FFF, 0, w);
`endif
    applyStimulus("sb101",    0, 1, 3'd0, 32'h101, 32'h0000005A, 5'd0, 4'b0010, 32'h5A5A5A5A, 0, 0, 32'h0, 0, w);
    applyStimulus("lb101",    1, 0, 3'd0, 32'h101, 32'h0, 5'd18, 4'b0000, 32'h0, 1, 1, 32'h0000005A, 0, w);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
